instruction_fetch_unit: RTL and testbench

Upstream neighbour of the instruction decoder in the single-cycle CPU. It owns the 64-bit program counter and fetches one 32-bit instruction at a time from instruction memory over a req/ack handshake. It presents the instruction to the decoder with a valid/ready handshake. When the decoder consumes the instruction, the unit applies the branch resolution the decoder returns (taken, unconditional, offsets) and computes the next PC.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/instruction_fetch_unit_if.sv | 61 ++++++
 rtl/branch_target_calc.sv | 28 ++
 rtl/instruction_fetch_unit.sv | 106 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction/offset widths, PC step.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD
   } fetch_state_t;

   localparam int unsigned INSTR_W   = 32;
   localparam int unsigned BR_OFF_W  = 26;
   localparam int unsigned CBR_OFF_W = 19;
   localparam int unsigned PC_INCR   = 4;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory req/ack, decoder valid/ready with
// branch resolution, fetch enable and the retired-instruction counter.
interface instruction_fetch_unit_if
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W  = 64,
   parameter int unsigned CNT_W = 32
) ();

   logic                 fetch_en;
   logic                 imem_req;
   logic [PC_W-1:0]      imem_addr;
   logic                 imem_ack;
   logic [INSTR_W-1:0]   imem_rdata;
   logic [INSTR_W-1:0]   instruction;
   logic                 instr_valid;
   logic                 instr_ready;
   logic [PC_W-1:0]      pc_out;
   logic                 BrTaken;
   logic                 UnCondBr;
   logic [BR_OFF_W-1:0]  BR_addr;
   logic [CBR_OFF_W-1:0] COND_BR_addr;
   logic [CNT_W-1:0]     instr_count;

   // Fetch unit side.
   modport master (
      input  fetch_en,
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata,
      output instruction,
      output instr_valid,
      input  instr_ready,
      output pc_out,
      input  BrTaken,
      input  UnCondBr,
      input  BR_addr,
      input  COND_BR_addr,
      output instr_count
   );

   // Memory / decoder side.
   modport slave (
      output fetch_en,
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata,
      input  instruction,
      input  instr_valid,
      output instr_ready,
      input  pc_out,
      output BrTaken,
      output UnCondBr,
      output BR_addr,
      output COND_BR_addr,
      input  instr_count
   );

endinterface

// File: rtl/branch_target_calc.sv
// Next-PC computation: sequential step or PC-relative branch by a signed word
// offset. Purely combinational so the pipelined core can reuse it.
module branch_target_calc
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W = 64
) (
   input  logic [PC_W-1:0]      pc,
   input  logic                 UnCondBr,
   input  logic [BR_OFF_W-1:0]  BR_addr,
   input  logic [CBR_OFF_W-1:0] COND_BR_addr,
   input  logic                 BrTaken,
   output logic [PC_W-1:0]      next_pc
);

   logic [PC_W-1:0] br_off;
   logic [PC_W-1:0] cbr_off;
   logic [PC_W-1:0] offset;

   // Sign-extend the selected word offset to a byte offset; sums wrap silently.
   always_comb begin
      br_off  = {{(PC_W-BR_OFF_W){BR_addr[BR_OFF_W-1]}}, BR_addr} << 2;
      cbr_off = {{(PC_W-CBR_OFF_W){COND_BR_addr[CBR_OFF_W-1]}}, COND_BR_addr} << 2;
      offset  = UnCondBr ? br_off : cbr_off;
      next_pc = BrTaken ? (pc + offset) : (pc + PC_W'(PC_INCR));
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over req/ack,
// holds it for the decoder and steps the PC when the decoder consumes it.
module instruction_fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned     PC_W     = 64,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int unsigned     CNT_W    = 32
) (
   input logic                      clk,
   input logic                      reset_n,
   instruction_fetch_unit_if.master bus
);

   fetch_state_t       state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               req_q, req_d;
   logic               valid_q, valid_d;
   logic [PC_W-1:0]    next_pc;

   branch_target_calc #(
      .PC_W (PC_W)
   ) u_branch_target_calc (
      .pc           (pc_q),
      .UnCondBr     (bus.UnCondBr),
      .BR_addr      (bus.BR_addr),
      .COND_BR_addr (bus.COND_BR_addr),
      .BrTaken      (bus.BrTaken),
      .next_pc      (next_pc)
   );

   // Next-state logic; req/valid are computed here so they leave as flops.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (bus.fetch_en) begin
               state_d = FETCH;
               req_d   = 1'b1;
            end
         end
         FETCH: begin
            // fetch_en is not looked at: an issued request always completes.
            if (bus.imem_ack) begin
               instr_d = bus.imem_rdata;
               state_d = HOLD;
               req_d   = 1'b0;
               valid_d = 1'b1;
            end
         end
         HOLD: begin
            // valid_q is always set in HOLD, so ready alone marks a consume.
            if (bus.instr_ready) begin
               pc_d    = next_pc;
               cnt_d   = cnt_q + CNT_W'(1);
               valid_d = 1'b0;
               if (bus.fetch_en) begin
                  state_d = FETCH;
                  req_d   = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   // State registers; reset abandons any outstanding request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         valid_q <= valid_d;
      end
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = pc_q;
   assign bus.instruction = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.pc_out      = pc_q;
   assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. A second instance starting at the
// top of the address space with a 4-bit counter shares all stimulus, so PC and
// counter wrap-around are reached in a short run.
module tb_instruction_fetch_unit;
   import cpu_pkg::*;

   localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

   logic        clk = 1'b0;
   logic        reset_n;
   int unsigned n_total = 0;
   int unsigned n_bad   = 0;
   logic [63:0] pc_exp;

   instruction_fetch_unit_if #(.PC_W(64), .CNT_W(32)) bus ();
   instruction_fetch_unit_if #(.PC_W(64), .CNT_W(4))  bus_w ();

   instruction_fetch_unit #(
      .PC_W     (64),
      .RESET_PC (64'h0),
      .CNT_W    (32)
   ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   instruction_fetch_unit #(
      .PC_W     (64),
      .RESET_PC (WRAP_PC),
      .CNT_W    (4)
   ) u_dut_wrap (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_w)
   );

   assign bus_w.fetch_en     = bus.fetch_en;
   assign bus_w.imem_ack     = bus.imem_ack;
   assign bus_w.imem_rdata   = bus.imem_rdata;
   assign bus_w.instr_ready  = bus.instr_ready;
   assign bus_w.BrTaken      = bus.BrTaken;
   assign bus_w.UnCondBr     = bus.UnCondBr;
   assign bus_w.BR_addr      = bus.BR_addr;
   assign bus_w.COND_BR_addr = bus.COND_BR_addr;

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Unit must be in FETCH at addr; ack after lat wait cycles with data.
   task automatic serve(input int lat, input logic [31:0] data, input logic [63:0] addr);
      for (int i = 0; i < lat; i++) begin
         check_eq("req_wait", 64'(bus.imem_req), 64'd1);
         check_eq("addr_wait", bus.imem_addr, addr);
         step();
      end
      check_eq("req", 64'(bus.imem_req), 64'd1);
      check_eq("addr", bus.imem_addr, addr);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = data;
      step();
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;
      check_eq("valid", 64'(bus.instr_valid), 64'd1);
      check_eq("instr", 64'(bus.instruction), 64'(data));
      check_eq("pc_out", bus.pc_out, addr);
      check_eq("req_hold", 64'(bus.imem_req), 64'd0);
   endtask

   task automatic consume(input logic taken, input logic uncond,
                          input logic [25:0] br, input logic [18:0] cbr);
      bus.BrTaken      = taken;
      bus.UnCondBr     = uncond;
      bus.BR_addr      = br;
      bus.COND_BR_addr = cbr;
      bus.instr_ready  = 1'b1;
      step();
      bus.instr_ready  = 1'b0;
      bus.BrTaken      = 1'b0;
      bus.UnCondBr     = 1'b0;
      bus.BR_addr      = '0;
      bus.COND_BR_addr = '0;
      check_eq("valid_drop", 64'(bus.instr_valid), 64'd0);
   endtask

   initial begin
      reset_n          = 1'b0;
      bus.fetch_en     = 1'b0;
      bus.imem_ack     = 1'b0;
      bus.imem_rdata   = '0;
      bus.instr_ready  = 1'b0;
      bus.BrTaken      = 1'b0;
      bus.UnCondBr     = 1'b0;
      bus.BR_addr      = '0;
      bus.COND_BR_addr = '0;
      step();
      step();

      // Reset state
      check_eq("rst_req", 64'(bus.imem_req), 64'd0);
      check_eq("rst_valid", 64'(bus.instr_valid), 64'd0);
      check_eq("rst_instr", 64'(bus.instruction), 64'd0);
      check_eq("rst_cnt", 64'(bus.instr_count), 64'd0);
      check_eq("rst_addr", bus.imem_addr, 64'h0);
      check_eq("rst_addr_w", bus_w.imem_addr, WRAP_PC);
      check_eq("rst_cnt_w", 64'(bus_w.instr_count), 64'd0);
      bus.fetch_en = 1'b1;
      step();
      check_eq("rst_req_en", 64'(bus.imem_req), 64'd0);

      // Release with immediate ack: valid two cycles after release
      reset_n = 1'b1;
      step();
      check_eq("t1_req", 64'(bus.imem_req), 64'd1);
      check_eq("t1_addr", bus.imem_addr, 64'h0);
      check_eq("t1_valid0", 64'(bus.instr_valid), 64'd0);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'h9100_0421;
      step();
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;
      check_eq("t1_valid", 64'(bus.instr_valid), 64'd1);
      check_eq("t1_instr", 64'(bus.instruction), 64'h9100_0421);
      check_eq("t1_pc_out", bus.pc_out, 64'h0);
      check_eq("t1_pc_out_w", bus_w.pc_out, WRAP_PC);

      // Sequential consumes; wrap instance rolls its PC over to 0
      consume(1'b0, 1'b0, 26'h0, 19'h0);
      check_eq("t2_addr4", bus.imem_addr, 64'h4);
      check_eq("t2_cnt1", 64'(bus.instr_count), 64'd1);
      check_eq("t4_pc_wrap", bus_w.imem_addr, 64'h0);
      serve(3, 32'h8B02_0020, 64'h4);
      consume(1'b0, 1'b0, 26'h0, 19'h0);
      serve(3, 32'hCB03_0041, 64'h8);
      consume(1'b0, 1'b0, 26'h0, 19'h0);
      check_eq("t2_addr12", bus.imem_addr, 64'hC);
      check_eq("t2_cnt3", 64'(bus.instr_count), 64'd3);

      // Branches: 12 + 61*4 = 0x100
      serve(1, 32'hB400_0000, 64'hC);
      consume(1'b1, 1'b0, 26'h0, 19'd61);
      check_eq("t3_to100", bus.imem_addr, 64'h100);
      serve(2, 32'h1400_0000, 64'h100);
      consume(1'b1, 1'b1, 26'h3FF_FFFE, 19'h0);
      check_eq("t3_uncond", bus.imem_addr, 64'hF8);
      serve(0, 32'hB400_0001, 64'hF8);
      consume(1'b1, 1'b0, 26'h0, 19'd2);
      check_eq("t3_back100", bus.imem_addr, 64'h100);
      serve(1, 32'hB400_0002, 64'h100);
      consume(1'b1, 1'b0, 26'h0, 19'd5);
      check_eq("t3_cond", bus.imem_addr, 64'h114);
      serve(0, 32'h1400_0003, 64'h114);
      consume(1'b0, 1'b1, 26'h3FF_FFFF, 19'h0);
      check_eq("t3_not_taken", bus.imem_addr, 64'h118);
      serve(0, 32'h1400_0004, 64'h118);
      consume(1'b1, 1'b1, 26'h3FF_FFFF, 19'h0);
      check_eq("t3_minus4", bus.imem_addr, 64'h114);
      serve(1, 32'hB400_0005, 64'h114);
      consume(1'b1, 1'b0, 26'h0, 19'h4_0000);
      check_eq("t3_cond_min", bus.imem_addr, 64'hFFFF_FFFF_FFF0_0114);

      // Six more sequential consumes: wrap instance counter 15 -> 0
      pc_exp = 64'hFFFF_FFFF_FFF0_0114;
      for (int i = 0; i < 6; i++) begin
         serve(i % 3, 32'h0000_1000 + 32'(i), pc_exp);
         if (i == 5) check_eq("t4_cnt_w15", 64'(bus_w.instr_count), 64'hF);
         consume(1'b0, 1'b0, 26'h0, 19'h0);
         pc_exp = pc_exp + 64'd4;
      end
      check_eq("t4_cnt16", 64'(bus.instr_count), 64'd16);
      check_eq("t4_cnt_wrap", 64'(bus_w.instr_count), 64'd0);
      check_eq("t4_addr", bus.imem_addr, 64'hFFFF_FFFF_FFF0_012C);

      // fetch_en low in HOLD: consume goes to IDLE, then restart
      serve(1, 32'hAA55_1234, 64'hFFFF_FFFF_FFF0_012C);
      bus.fetch_en = 1'b0;
      consume(1'b0, 1'b0, 26'h0, 19'h0);
      check_eq("t6_req_idle", 64'(bus.imem_req), 64'd0);
      check_eq("t6_pc_adv", bus.imem_addr, 64'hFFFF_FFFF_FFF0_0130);
      step();
      check_eq("t6_req_stay", 64'(bus.imem_req), 64'd0);
      bus.fetch_en = 1'b1;
      step();
      check_eq("t6_req_up", 64'(bus.imem_req), 64'd1);
      check_eq("t6_addr_up", bus.imem_addr, 64'hFFFF_FFFF_FFF0_0130);

      // Reset during FETCH with ack arriving in the reset cycle
      step();
      check_eq("t5_req_pend", 64'(bus.imem_req), 64'd1);
      reset_n        = 1'b0;
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      #1;
      check_eq("t5_req", 64'(bus.imem_req), 64'd0);
      check_eq("t5_valid", 64'(bus.instr_valid), 64'd0);
      check_eq("t5_instr", 64'(bus.instruction), 64'd0);
      check_eq("t5_addr", bus.imem_addr, 64'h0);
      check_eq("t5_cnt", 64'(bus.instr_count), 64'd0);
      check_eq("t5_addr_w", bus_w.imem_addr, WRAP_PC);
      step();
      check_eq("t5_instr_rst", 64'(bus.instruction), 64'd0);
      check_eq("t5_valid_rst", 64'(bus.instr_valid), 64'd0);
      reset_n = 1'b1;
      step();
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;
      check_eq("t5_late_req", 64'(bus.imem_req), 64'd1);
      check_eq("t5_late_valid", 64'(bus.instr_valid), 64'd0);
      check_eq("t5_late_instr", 64'(bus.instruction), 64'd0);
      check_eq("t5_late_addr", bus.imem_addr, 64'h0);
      serve(1, 32'hD503_201F, 64'h0);
      check_eq("t5_cnt_after", 64'(bus.instr_count), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
